// File: rtl/ula_seq.sv
// Register-file sequencer for an external ULA: IDLE -> READ -> EXEC -> WB per command.
// Define ULA_SEQ_OVERLAP_EN to accept the next command during WB (3-cycle throughput).
module ula_seq #(
  parameter  int unsigned BITS = 16,
  parameter  int unsigned NREG = 8,
  localparam int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [4:0]      cmd_op,
  input  logic [AW-1:0]   cmd_rd,
  input  logic [AW-1:0]   cmd_ra,
  input  logic [AW-1:0]   cmd_rb,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [4:0]      alu_op,
  input  logic [BITS-1:0] alu_resu,
  input  logic            alu_o,
  input  logic            alu_c,
  input  logic            alu_s,
  input  logic            alu_z,
  output logic            done,
  output logic [3:0]      flags,
  input  logic [AW-1:0]   dbg_addr,
  output logic [BITS-1:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WB
  } state_t;

  state_t          state_q;
  logic [BITS-1:0] regs_q [NREG];
  logic [4:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [AW-1:0]   ra_q;
  logic [AW-1:0]   rb_q;
  logic [BITS-1:0] alu_a_q;
  logic [BITS-1:0] alu_b_q;
  logic [4:0]      alu_op_q;
  logic [BITS-1:0] res_q;
  logic [3:0]      hflags_q;
  logic [3:0]      flags_q;
  logic            done_q;
  logic            accept;

  // R0 is hardwired to zero on every read path; its storage is never written.
  function automatic logic [BITS-1:0] rd_reg(input logic [AW-1:0] addr);
    return (addr == '0) ? '0 : regs_q[addr];
  endfunction

`ifdef ULA_SEQ_OVERLAP_EN
  assign cmd_ready = (state_q == IDLE) || (state_q == WB);
`else
  assign cmd_ready = (state_q == IDLE);
`endif

  assign accept   = cmd_valid && cmd_ready;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign done     = done_q;
  assign flags    = flags_q;
  assign dbg_data = rd_reg(dbg_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      res_q    <= '0;
      hflags_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q <= cmd_op;
        rd_q <= cmd_rd;
        ra_q <= cmd_ra;
        rb_q <= cmd_rb;
      end
      case (state_q)
        IDLE: if (accept) state_q <= READ;
        READ: begin
          alu_a_q  <= rd_reg(ra_q);
          alu_b_q  <= rd_reg(rb_q);
          alu_op_q <= op_q;
          state_q  <= EXEC;
        end
        EXEC: begin
          res_q    <= alu_resu;
          hflags_q <= {alu_o, alu_c, alu_s, alu_z};
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          if (rd_q != '0) regs_q[rd_q] <= res_q;
          flags_q <= hflags_q;
          // A command captured here reads its sources next cycle, after this write lands.
          state_q <= accept ? READ : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Randomized self-checking bench for ula_seq with an external ULA model and a
// command-level reference model of the register file and flags.
module tb_ula_seq;
`ifdef ULA_SEQ_OVERLAP_EN
  localparam int SPACING = 3;
`else
  localparam int SPACING = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb;
  logic [15:0] alu_a, alu_b, alu_resu;
  logic [4:0]  alu_op;
  logic        alu_o, alu_c, alu_s, alu_z;
  logic        done;
  logic [3:0]  flags;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic [15:0] imm;

  ula_seq #(.BITS(16), .NREG(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_resu(alu_resu),
    .alu_o(alu_o), .alu_c(alu_c), .alu_s(alu_s), .alu_z(alu_z),
    .done(done), .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ULA behaviour: op0 add, op1 sub, op2 and, op3 xor, op31 load imm. Returns {O,C,S,Z,result}.
  function automatic logic [19:0] ula(input logic [4:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] im);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int u = 0;
    int s = 0;
    logic [15:0] r;
    logic o, c;
    o = 1'b0;
    c = 1'b0;
    case (op)
      5'd0: begin u = ua + ub; s = sa + sb; r = u[15:0]; c = (u > 65535); o = (s > 32767) || (s < -32768); end
      5'd1: begin u = ua - ub; s = sa - sb; r = u[15:0]; c = (u < 0);     o = (s > 32767) || (s < -32768); end
      5'd2: r = a & b;
      5'd3: r = a ^ b;
      5'd31: r = im;
      default: r = '0;
    endcase
    return {o, c, r[15], (r == 16'h0000), r};
  endfunction

  always_comb {alu_o, alu_c, alu_s, alu_z, alu_resu} = ula(alu_op, alu_a, alu_b, imm);

  typedef struct {
    int         cyc;
    logic [2:0] rd;
    logic [3:0] fl;
  } exp_t;

  exp_t        expq[$];
  int          acc_q[$];
  logic [15:0] mreg [8];
  int          cyc = 0;
  logic        flag_pend = 1'b0;
  logic [3:0]  flag_exp;
  exp_t        e;
  logic [19:0] mr;

  function automatic logic [15:0] rdm(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : mreg[a];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: each accepted command is applied in order; done must follow 3 cycles later.
  always @(negedge clk) begin
    if (flag_pend) begin
      chk("flags_after_wb", {28'd0, flags}, {28'd0, flag_exp});
      flag_pend = 1'b0;
    end
    if (done) begin
      if (expq.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else begin
        e = expq.pop_front();
        chk("done_latency", cyc, e.cyc);
        flag_pend = 1'b1;
        flag_exp  = e.fl;
      end
    end
    if (!rst && cmd_valid && cmd_ready) begin
      mr = ula(cmd_op, rdm(cmd_ra), rdm(cmd_rb), imm);
      if (cmd_rd != 3'd0) mreg[cmd_rd] = mr[15:0];
      expq.push_back('{cyc + 3, cmd_rd, mr[19:16]});
      acc_q.push_back(cyc);
    end
  end

  task automatic rdchk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(tag, {16'd0, dbg_data}, {16'd0, exp});
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb);
    logic acc;
    acc = 1'b0;
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("accept_timeout", {31'd0, acc}, 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (expq.size() == 0 && !flag_pend) break;
      @(posedge clk);
      #1;
    end
    chk("drain_timeout", expq.size() + int'(flag_pend), 0);
  endtask

  task automatic load(input logic [2:0] rd, input logic [15:0] val);
    imm = val;
    send(5'd31, rd, 3'd0, 3'd0);
    drain();
  endtask

  task automatic clear_model();
    expq.delete();
    flag_pend = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0; cmd_rb = '0;
    dbg_addr = '0; imm = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_alu_op", {27'd0, alu_op}, 32'd0);
    chk("rst_alu_ab", {alu_a, alu_b}, 32'd0);
    for (int i = 0; i < 8; i++) rdchk("rst_reg", 3'(i), 16'h0000);
    @(posedge clk);
    #1;

    load(3'd1, 16'h7FFF);
    load(3'd2, 16'h0001);
    rdchk("pre_r1", 3'd1, 16'h7FFF);
    rdchk("pre_r2", 3'd2, 16'h0001);
    send(5'd0, 3'd3, 3'd1, 3'd2);
    drain();
    rdchk("add_r3", 3'd3, 16'h8000);
    chk("add_flags", {28'd0, flags}, 32'b1010);

    load(3'd7, 16'h0000);
    chk("zero_load_flags", {28'd0, flags}, 32'b0001);
    send(5'd0, 3'd0, 3'd1, 3'd1);
    drain();
    rdchk("r0_zero", 3'd0, 16'h0000);
    chk("r0_flags", {28'd0, flags}, 32'b1010);

    load(3'd1, 16'hFFFF);
    acc_q.delete();
    send(5'd0, 3'd1, 3'd1, 3'd2);
    send(5'd0, 3'd4, 3'd3, 3'd2);
    send(5'd0, 3'd5, 3'd4, 3'd4);
    drain();
    chk("stream_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("spacing_1", acc_q[1] - acc_q[0], SPACING);
      chk("spacing_2", acc_q[2] - acc_q[1], SPACING);
    end
    rdchk("wrap_r1", 3'd1, 16'h0000);
    rdchk("chain_r4", 3'd4, 16'h8001);
    rdchk("chain_r5", 3'd5, 16'h0002);
    chk("chain_flags", {28'd0, flags}, 32'b1100);

    send(5'd0, 3'd6, 3'd5, 3'd5);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end
    rdchk("abort_r6", 3'd6, 16'h0000);
    rdchk("abort_r5", 3'd5, 16'h0000);
    chk("abort_flags", {28'd0, flags}, 32'd0);
    @(posedge clk);
    #1;

    for (int r = 1; r < 8; r++) load(3'(r), 16'($urandom));
    for (int k = 0; k < 60; k++) begin
      send(5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();
    for (int i = 0; i < 8; i++) rdchk("rand_reg", 3'(i), rdm(3'(i)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
